alu_field_mul: RTL and testbench
================================

Name: alu_field_mul

Overview:
- Parametrised, iterative field multiplier for the wide-word ALU datapath.
- Extracts block-aligned fields from two wide operands and multiplies them, radix 2^RADIX_BITS per cycle, signed or unsigned.
- Inserts the low or high half of the product back into the first operand at its field offset.
- Generalises the fixed 512-bit, radix-2, unsigned, low-half-only multiply with a start/ready/done handshake and an overflow flag.

Parameters:
- WORD_SIZE, 512, width of in1/in2/res in bits.
- BLOCK_BITS, 16, granularity of fields (bits per block).
- OP_SIZE, 5, width of size/offset selectors; BLOCK_COUNT = WORD_SIZE/BLOCK_BITS must equal 2^OP_SIZE.
- RADIX_BITS, 2, multiplier bits consumed per RUN cycle (1, 2 or 4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- in1  in  WORD_SIZE  operand A source and insertion base.
- in2  in  WORD_SIZE  operand B source.
- op_size  in  OP_SIZE  field width = (op_size+1)*BLOCK_BITS bits (W).
- op_offset1  in  OP_SIZE  block offset of A field and of result field.
- op_offset2  in  OP_SIZE  block offset of B field.
- is_signed  in  1  1 = two's-complement operands.
- high_half  in  1  1 = write product bits [2W-1:W], 0 = bits [W-1:0].
- ready  out  1  idle/accepting.
- done  out  1  one-cycle pulse when res is valid.
- res  out  WORD_SIZE  in1 with field replaced by the selected product half.
- zero  out  1  inserted field is all zero.
- overflow  out  1  low half does not represent the full product.

Behaviour:
- Reset: state IDLE; ready=1, done=0, res=0, zero=0, overflow=0. Reset mid-operation aborts with no done pulse.
- Accept: on the clk edge where start=1 and ready=1, latch in1, the extracted fields, offsets, W, is_signed and high_half. Input changes afterwards have no effect.
- start while ready=0 is ignored.
- Extraction: field = (in & mask) >> (offset*BLOCK_BITS). Blocks beyond BLOCK_COUNT-1 are dropped (truncated at word top), so the effective field holds fewer significant bits and the upper field bits are 0.
- Signed mode: bit W-1 of each field is the sign. Magnitudes |A| and |B| are computed at accept; result sign = sA xor sB.
- FSM IDLE -> RUN:
  - Each RUN cycle first tests the remaining multiplier |B|.
  - If it is 0, go to FIX with no accumulation.
  - Otherwise acc += |A| * (low RADIX_BITS of remaining), shift remaining right by RADIX_BITS, shift the |A| copy left by RADIX_BITS.
  - acc is 2W bits wide (sized for the maximum W = WORD_SIZE).
- FSM RUN -> FIX (one cycle):
  - Negate the 2W-bit acc if the result sign is negative.
  - Select the half; shift it left by op_offset1*BLOCK_BITS; mask it to the field blocks that are in range; OR it with latched in1 with those blocks cleared.
  - Register res, zero and overflow.
  - Next state IDLE with ready=1 and done=1 for exactly one cycle.
- Latency: ready is low for 2 + ceil(L/RADIX_BITS) cycles, where L = bit length of |B| (L=0 when B=0).
  - Back-to-back: start may be asserted in the done cycle and is accepted.
- overflow:
  - Unsigned: product bits [2W-1:W] are nonzero.
  - Signed: those bits are not all copies of bit W-1.
  - Computed regardless of high_half.
- res, zero and overflow hold their values until the next done.

Test Plan:
- Unsigned, op_size=0, A=0x00FF at offset1=0, B=0x0101 at offset2=3, RADIX_BITS=2 -> ready low 7 cycles, done pulse, res[15:0]=0xFFFF, other blocks equal in1, overflow=0, zero=0.
- Unsigned 0xFFFF*0xFFFF, W=16 -> high_half=0 gives field 0x0001 with overflow=1; rerun with high_half=1 gives field 0xFFFE.
- Signed, A=0xFFFD (-3), B=0x0005 -> low field 0xFFF1, high field 0xFFFF, overflow=0. Signed 0x8000*0x8000 -> low 0x0000, overflow=1, zero=1.
- B=0, in1 all ones, op_size=1, offset1=4 -> ready low exactly 2 cycles, res bits [95:64]=0, all others 1, zero=1.
- Truncation: op_size=3, offset1=30, in1 all ones, A field=0x0003, B=0x0002 -> res blocks 30,31 = 0x0006/0x0000, blocks 0-29 unchanged.
- rst asserted during RUN, then start asserted while busy -> after rst, ready=1, res=0 with no done pulse; a busy-time start is ignored and the next accepted op still completes correctly.

Source files
------------

// File: rtl/alu_field_mul_if.sv
// Operand/result bundle for the iterative field multiplier.
// Handshake: the multiplier samples start on a rising edge only while ready=1; done pulses for one
// cycle with ready=1; res/zero/overflow hold their values until the next done.
interface alu_field_mul_if #(
  parameter int WORD_SIZE = 512,
  parameter int OP_SIZE   = 5
) ();
  logic                 start;
  logic [WORD_SIZE-1:0] in1;
  logic [WORD_SIZE-1:0] in2;
  logic [OP_SIZE-1:0]   op_size;
  logic [OP_SIZE-1:0]   op_offset1;
  logic [OP_SIZE-1:0]   op_offset2;
  logic                 is_signed;
  logic                 high_half;
  logic                 ready;
  logic                 done;
  logic [WORD_SIZE-1:0] res;
  logic                 zero;
  logic                 overflow;

  modport master (
    output start, in1, in2, op_size, op_offset1, op_offset2, is_signed, high_half,
    input  ready, done, res, zero, overflow
  );

  modport slave (
    input  start, in1, in2, op_size, op_offset1, op_offset2, is_signed, high_half,
    output ready, done, res, zero, overflow
  );
endinterface

// File: rtl/alu_field_mul.sv
// Iterative sign-magnitude multiplier on block-aligned fields of two wide words; the selected
// product half is written back into in1 at the first operand's field offset.
module alu_field_mul #(
  parameter int WORD_SIZE  = 512,
  parameter int BLOCK_BITS = 16,
  parameter int OP_SIZE    = 5,
  parameter int RADIX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_field_mul_if.slave    bus,
  output logic [1:0]        dbg_state
);
  localparam int BLOCK_COUNT = WORD_SIZE / BLOCK_BITS;
  localparam int ACC_W       = 2 * WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WORD_SIZE-1:0] in1_q, rem_q;
  logic [ACC_W-1:0]     acc_q, a_sh_q;
  logic [OP_SIZE-1:0]   size_q, off1_q;
  logic                 neg_q, signed_q, high_q;
  logic                 done_q, zero_q, ovf_q;
  logic [WORD_SIZE-1:0] res_q;

  // Ones in the low (sz+1)*BLOCK_BITS bits.
  function automatic logic [WORD_SIZE-1:0] width_mask(input logic [OP_SIZE-1:0] sz);
    return {WORD_SIZE{1'b1}} >> ((BLOCK_COUNT - 1 - int'(sz)) * BLOCK_BITS);
  endfunction

  // Field extraction and magnitudes, evaluated on the live inputs for the accept edge.
  logic [WORD_SIZE-1:0] mask_in, top_in, fa, fb, mag_a, mag_b;
  logic                 sa, sb;

  always_comb begin
    mask_in = width_mask(bus.op_size);
    top_in  = mask_in & ~(mask_in >> 1);
    fa      = (bus.in1 >> (int'(bus.op_offset1) * BLOCK_BITS)) & mask_in;
    fb      = (bus.in2 >> (int'(bus.op_offset2) * BLOCK_BITS)) & mask_in;
    sa      = bus.is_signed && (|(fa & top_in));
    sb      = bus.is_signed && (|(fb & top_in));
    mag_a   = sa ? ((-fa) & mask_in) : fa;
    mag_b   = sb ? ((-fb) & mask_in) : fb;
  end

  logic [ACC_W-1:0] partial;

  always_comb begin
    partial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (rem_q[i]) partial = partial + (a_sh_q << i);
    end
  end

  // Sign fix-up, half selection and re-insertion for the FIX cycle.
  logic [ACC_W-1:0]     prod;
  logic [WORD_SIZE-1:0] mask_q, top_q, lo, hi, ext, half, fmask, ins;
  int                   w_sh, o_sh;

  always_comb begin
    mask_q = width_mask(size_q);
    top_q  = mask_q & ~(mask_q >> 1);
    w_sh   = (int'(size_q) + 1) * BLOCK_BITS;
    o_sh   = int'(off1_q) * BLOCK_BITS;
    prod   = neg_q ? -acc_q : acc_q;
    lo     = prod[WORD_SIZE-1:0] & mask_q;
    hi     = WORD_SIZE'(prod >> w_sh) & mask_q;
    ext    = (signed_q && (|(lo & top_q))) ? mask_q : '0;
    half   = high_q ? hi : lo;
    fmask  = mask_q << o_sh;
    ins    = (half << o_sh) & fmask;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (rem_q == '0) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      in1_q    <= bus.in1;
      rem_q    <= mag_b;
      a_sh_q   <= ACC_W'(mag_a);
      acc_q    <= '0;
      neg_q    <= sa ^ sb;
      signed_q <= bus.is_signed;
      high_q   <= bus.high_half;
      size_q   <= bus.op_size;
      off1_q   <= bus.op_offset1;
    end else if (state == RUN && rem_q != '0) begin
      acc_q  <= acc_q + partial;
      rem_q  <= rem_q >> RADIX_BITS;
      a_sh_q <= a_sh_q << RADIX_BITS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      if (state == FIX) begin
        res_q  <= (in1_q & ~fmask) | ins;
        zero_q <= (ins == '0);
        ovf_q  <= (hi != ext);
      end
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.res      = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_alu_field_mul.sv
// Directed bench for alu_field_mul: a block-level arithmetic model feeds an expected queue that a
// single compare process checks on every done pulse, plus literal checks of hand-worked cases.
module tb_alu_field_mul;
  localparam int WS    = 512;
  localparam int RADIX = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  alu_field_mul_if #(.WORD_SIZE(WS), .OP_SIZE(5)) bus ();

  alu_field_mul #(
    .WORD_SIZE(WS), .BLOCK_BITS(16), .OP_SIZE(5), .RADIX_BITS(RADIX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WS-1:0] exp_q[$];
  bit            exp_z_q[$];
  bit            exp_ov_q[$];

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WS-1:0] rand_word();
    logic [WS-1:0] w;
    for (int i = 0; i < WS / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [WS-1:0] put(input logic [WS-1:0] w, input int blk, input logic [15:0] v);
    logic [WS-1:0] r;
    r = w;
    r[blk*16 +: 16] = v;
    return r;
  endfunction

  // Model: fields gathered block by block, sign-extended, multiplied as plain wide integers.
  function automatic void model(input logic [WS-1:0] a_word, input logic [WS-1:0] b_word,
                                input int size, input int off1, input int off2,
                                input bit sgn, input bit high,
                                output logic [WS-1:0] r, output bit z, output bit ov,
                                output int lat);
    int              w, blen;
    logic [2*WS-1:0] a, b, p, mb;
    logic [15:0]     blkv;
    w = (size + 1) * 16;
    a = '0;
    b = '0;
    for (int j = 0; j <= size; j++) begin
      if (off1 + j < 32) a[j*16 +: 16] = a_word[(off1+j)*16 +: 16];
      if (off2 + j < 32) b[j*16 +: 16] = b_word[(off2+j)*16 +: 16];
    end
    if (sgn && a[w-1]) for (int k = w; k < 2*WS; k++) a[k] = 1'b1;
    if (sgn && b[w-1]) for (int k = w; k < 2*WS; k++) b[k] = 1'b1;
    p = a * b;
    ov = 1'b0;
    for (int k = w; k < 2*w; k++) if (p[k] != (sgn ? p[w-1] : 1'b0)) ov = 1'b1;
    r = a_word;
    z = 1'b1;
    for (int j = 0; j <= size; j++) begin
      if (off1 + j < 32) begin
        blkv = p[(high ? w : 0) + j*16 +: 16];
        r[(off1+j)*16 +: 16] = blkv;
        if (blkv != 16'h0) z = 1'b0;
      end
    end
    mb = b[2*WS-1] ? -b : b;
    blen = 0;
    for (int k = 0; k < 2*WS; k++) if (mb[k]) blen = k + 1;
    lat = 2 + (blen + RADIX - 1) / RADIX;
  endfunction

  always begin
    @(negedge clk);
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", WS'(bus.done), '0);
      end else begin
        chk("res", bus.res, exp_q.pop_front());
        chk("zero", WS'(bus.zero), WS'(exp_z_q.pop_front()));
        chk("overflow", WS'(bus.overflow), WS'(exp_ov_q.pop_front()));
      end
    end
  end

  // Issues one op, pokes start with junk while busy, and reports the ready-low cycle count.
  task automatic run_op(input logic [WS-1:0] a_word, input logic [WS-1:0] b_word,
                        input int size, input int off1, input int off2,
                        input bit sgn, input bit high, output int cnt);
    logic [WS-1:0] er;
    bit            ez, eov;
    int            lat, guard;
    model(a_word, b_word, size, off1, off2, sgn, high, er, ez, eov, lat);
    guard = 0;
    while (!bus.ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_start", WS'(bus.ready), WS'(1));
    bus.in1        = a_word;
    bus.in2        = b_word;
    bus.op_size    = 5'(size);
    bus.op_offset1 = 5'(off1);
    bus.op_offset2 = 5'(off2);
    bus.is_signed  = sgn;
    bus.high_half  = high;
    bus.start      = 1'b1;
    exp_q.push_back(er);
    exp_z_q.push_back(ez);
    exp_ov_q.push_back(eov);
    @(posedge clk);
    #1;
    bus.in1        = rand_word();
    bus.in2        = rand_word();
    bus.op_size    = 5'($urandom_range(0, 31));
    bus.op_offset1 = 5'($urandom_range(0, 31));
    bus.op_offset2 = 5'($urandom_range(0, 31));
    bus.is_signed  = 1'($urandom_range(0, 1));
    bus.high_half  = 1'($urandom_range(0, 1));
    cnt = 0;
    while (cnt < 600) begin
      @(negedge clk);
      if (bus.ready) break;
      cnt++;
      bus.start = (cnt < lat - 1);
    end
    bus.start = 1'b0;
    chk("latency", WS'(cnt), WS'(lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WS-1:0] w1, w2, ones;
    int            cnt;
    ones           = '1;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.in1        = '0;
    bus.in2        = '0;
    bus.op_size    = '0;
    bus.op_offset1 = '0;
    bus.op_offset2 = '0;
    bus.is_signed  = 1'b0;
    bus.high_half  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", WS'(bus.ready), WS'(1));
    chk("rst_done", WS'(bus.done), '0);
    chk("rst_res", bus.res, '0);
    chk("rst_zero", WS'(bus.zero), '0);
    chk("rst_overflow", WS'(bus.overflow), '0);

    // 0x00FF * 0x0101, unsigned, field 0
    w1 = put(rand_word(), 0, 16'h00FF);
    w2 = put(rand_word(), 3, 16'h0101);
    run_op(w1, w2, 0, 0, 3, 1'b0, 1'b0, cnt);
    chk("t1_latency", WS'(cnt), WS'(7));
    chk("t1_field", WS'(bus.res[15:0]), WS'(16'hFFFF));
    chk("t1_rest", WS'(bus.res[WS-1:16]), WS'(w1[WS-1:16]));
    chk("t1_overflow", WS'(bus.overflow), '0);
    chk("t1_zero", WS'(bus.zero), '0);

    // 0xFFFF * 0xFFFF unsigned, low then high half
    w1 = put(rand_word(), 5, 16'hFFFF);
    w2 = put(rand_word(), 9, 16'hFFFF);
    run_op(w1, w2, 0, 5, 9, 1'b0, 1'b0, cnt);
    chk("t2_low", WS'(bus.res[95:80]), WS'(16'h0001));
    chk("t2_low_ovf", WS'(bus.overflow), WS'(1));
    run_op(w1, w2, 0, 5, 9, 1'b0, 1'b1, cnt);
    chk("t2_high", WS'(bus.res[95:80]), WS'(16'hFFFE));
    chk("t2_latency", WS'(cnt), WS'(10));

    // signed -3 * 5
    w1 = put(rand_word(), 2, 16'hFFFD);
    w2 = put(rand_word(), 7, 16'h0005);
    run_op(w1, w2, 0, 2, 7, 1'b1, 1'b0, cnt);
    chk("t3_low", WS'(bus.res[47:32]), WS'(16'hFFF1));
    chk("t3_ovf", WS'(bus.overflow), '0);
    run_op(w1, w2, 0, 2, 7, 1'b1, 1'b1, cnt);
    chk("t3_high", WS'(bus.res[47:32]), WS'(16'hFFFF));

    // signed 0x8000 * 0x8000
    w1 = put(rand_word(), 0, 16'h8000);
    w2 = put(rand_word(), 1, 16'h8000);
    run_op(w1, w2, 0, 0, 1, 1'b1, 1'b0, cnt);
    chk("t4_low", WS'(bus.res[15:0]), '0);
    chk("t4_ovf", WS'(bus.overflow), WS'(1));
    chk("t4_zero", WS'(bus.zero), WS'(1));

    // multiplier zero: two-cycle latency, 32-bit field at block 4 cleared
    run_op(ones, '0, 1, 4, 10, 1'b0, 1'b0, cnt);
    chk("t5_latency", WS'(cnt), WS'(2));
    chk("t5_res", bus.res, put(put(ones, 4, 16'h0), 5, 16'h0));
    chk("t5_zero", WS'(bus.zero), WS'(1));

    // field truncated at the top of the word
    w1 = put(put(ones, 30, 16'h0003), 31, 16'h0000);
    w2 = put('0, 0, 16'h0002);
    run_op(w1, w2, 3, 30, 0, 1'b0, 1'b0, cnt);
    chk("t6_res", bus.res, put(put(ones, 30, 16'h0006), 31, 16'h0000));
    chk("t6_latency", WS'(cnt), WS'(3));

    // reset during RUN with a busy-time start, then a normal op
    bus.in1        = rand_word();
    bus.in2        = ones;
    bus.op_size    = 5'd31;
    bus.op_offset1 = 5'd0;
    bus.op_offset2 = 5'd0;
    bus.is_signed  = 1'b0;
    bus.high_half  = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.in2   = put('0, 0, 16'h0001);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", WS'(bus.ready), WS'(1));
    chk("abort_res", bus.res, '0);
    chk("abort_done", WS'(bus.done), '0);
    repeat (5) @(negedge clk);
    w1 = rand_word();
    w2 = rand_word();
    run_op(w1, w2, 7, 3, 20, 1'b1, 1'b0, cnt);

    // assorted fields, back to back
    for (int i = 0; i < 8; i++) begin
      run_op(rand_word(), rand_word(), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cnt);
    end
    run_op(rand_word(), rand_word(), 31, 0, 0, 1'b1, 1'b1, cnt);

    repeat (4) @(negedge clk);
    chk("queue_drained", WS'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
